// File: rtl/csel_pkg.sv
// -----------------------------------------------------------------------------
// csel_pkg
// Shared types and helpers for the pipelined carry-select adder.
//   stage_ctrl_t  : per-stage control payload (valid, carry, operand sign bits).
//                   The partial sum sits beside it because its width depends on
//                   the instance parameters.
//   block_cfg_ok  : legality check for a WIDTH/BLOCK pair.
// -----------------------------------------------------------------------------
package csel_pkg;

  typedef struct packed {
    logic valid;   // beat present in this stage
    logic carry;   // carry into the next slice (or carry into this one, on the source side)
    logic a_msb;   // sign of operand A
    logic bx_msb;  // sign of the conditioned operand B (~b in subtract mode)
  } stage_ctrl_t;

  // WIDTH must be a positive multiple of BLOCK, with BLOCK at least 1.
  function automatic bit block_cfg_ok(input int width, input int block);
    if (block < 1) return 1'b0;
    if (width < block) return 1'b0;
    return (width % block) == 0;
  endfunction

endpackage

// File: rtl/csel_slice.sv
// -----------------------------------------------------------------------------
// csel_slice
// Combinational BLOCK-bit carry-select slice. Both carry-in cases are summed
// up front; the late-arriving carry only drives the final mux.
//   a, b    : slice operands
//   cin_sel : carry into the slice, selects between the two precomputed sums
//   sum     : slice sum
//   cout    : carry out of the slice
// -----------------------------------------------------------------------------
module csel_slice #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin_sel,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK-1:0] sum_c0;
  logic [BLOCK-1:0] sum_c1;
  logic             cout_c0;
  logic             cout_c1;

  ripple_carry_adder #(.W(BLOCK)) u_rca_c0 (
    .a    (a),
    .b    (b),
    .cin  (1'b0),
    .sum  (sum_c0),
    .cout (cout_c0)
  );

  ripple_carry_adder #(.W(BLOCK)) u_rca_c1 (
    .a    (a),
    .b    (b),
    .cin  (1'b1),
    .sum  (sum_c1),
    .cout (cout_c1)
  );

  assign sum  = cin_sel ? sum_c1  : sum_c0;
  assign cout = cin_sel ? cout_c1 : cout_c0;

endmodule

// File: rtl/ripple_carry_adder.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder
// Plain W-bit ripple-carry adder, used as the building block of each slice.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^W
//   cout : carry out of bit W-1
// -----------------------------------------------------------------------------
module ripple_carry_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/csel_pipe_adder.sv
// -----------------------------------------------------------------------------
// csel_pipe_adder
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// One BLOCK-bit slice is resolved per stage, so latency is WIDTH/BLOCK cycles
// and throughput is one beat per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready ignores in_valid)
//   a, b, carry_in, sub  : operands; sub=1 computes a - b - carry_in
//   out_valid / out_ready: output handshake
//   sum, cout, overflow  : result mod 2^WIDTH, raw MSB carry, signed overflow
// -----------------------------------------------------------------------------
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  if (!block_cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
    $fatal(1, "csel_pipe_adder: WIDTH must be a positive multiple of BLOCK");
  end

  localparam int NBLK = WIDTH / BLOCK;
  localparam int LAST = NBLK - 1;

  // Stage registers
  stage_ctrl_t      ctrl_reg [NBLK];
  logic [WIDTH-1:0] sum_reg  [NBLK];
  logic [WIDTH-1:0] a_reg    [NBLK];
  logic [WIDTH-1:0] bx_reg   [NBLK];
  logic             overflow_reg;

  // What each stage sees on its input side: stage 0 from the ports,
  // stage k from stage k-1. ctrl_src.carry is the carry INTO the stage.
  stage_ctrl_t      ctrl_src [NBLK];
  logic [WIDTH-1:0] sum_src  [NBLK];
  logic [WIDTH-1:0] a_src    [NBLK];
  logic [WIDTH-1:0] bx_src   [NBLK];

  logic [BLOCK-1:0] slice_sum  [NBLK];
  logic             slice_cout [NBLK];
  logic [WIDTH-1:0] sum_next   [NBLK];
  logic             overflow_next;

  logic             advance;
  logic [WIDTH-1:0] bx_in;
  logic             cin_eff;

  // The whole pipeline moves in lockstep, so a single enable suffices.
  assign advance  = !ctrl_reg[LAST].valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    // Subtraction as a + ~b + 1, with carry_in acting as borrow-in.
    bx_in   = sub ? ~b : b;
    cin_eff = sub ? ~carry_in : carry_in;

    ctrl_src[0] = '{valid: in_valid, carry: cin_eff, a_msb: a[WIDTH-1], bx_msb: bx_in[WIDTH-1]};
    sum_src[0]  = '0;
    a_src[0]    = a;
    bx_src[0]   = bx_in;
    for (int k = 1; k < NBLK; k++) begin
      ctrl_src[k] = ctrl_reg[k-1];
      sum_src[k]  = sum_reg[k-1];
      a_src[k]    = a_reg[k-1];
      bx_src[k]   = bx_reg[k-1];
    end
  end

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_stage
    csel_slice #(.BLOCK(BLOCK)) u_slice (
      .a       (a_src[gi][gi*BLOCK +: BLOCK]),
      .b       (bx_src[gi][gi*BLOCK +: BLOCK]),
      .cin_sel (ctrl_src[gi].carry),
      .sum     (slice_sum[gi]),
      .cout    (slice_cout[gi])
    );
  end

  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      sum_next[k] = sum_src[k];
      sum_next[k][k*BLOCK +: BLOCK] = slice_sum[k];
    end
    // Same-sign operands producing a result of the other sign. The MSB of the
    // result is the top bit of the last slice, resolved in this very stage.
    overflow_next = (ctrl_src[LAST].a_msb == ctrl_src[LAST].bx_msb) &&
                    (slice_sum[LAST][BLOCK-1] != ctrl_src[LAST].a_msb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) begin
        ctrl_reg[k] <= '0;
        sum_reg[k]  <= '0;
        a_reg[k]    <= '0;
        bx_reg[k]   <= '0;
      end
      overflow_reg <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NBLK; k++) begin
        ctrl_reg[k] <= '{valid:  ctrl_src[k].valid,
                         carry:  slice_cout[k],
                         a_msb:  ctrl_src[k].a_msb,
                         bx_msb: ctrl_src[k].bx_msb};
        sum_reg[k]  <= sum_next[k];
        a_reg[k]    <= a_src[k];
        bx_reg[k]   <= bx_src[k];
      end
      overflow_reg <= overflow_next;
    end
  end

  assign out_valid = ctrl_reg[LAST].valid;
  assign sum       = sum_reg[LAST];
  assign cout      = ctrl_reg[LAST].carry;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_csel_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_csel_pipe_adder
// Scoreboard bench for csel_pipe_adder: expected results are queued when a beat
// is accepted and compared in order when a result is transferred.
// -----------------------------------------------------------------------------
module tb_csel_pipe_adder;

  localparam int W  = 32;
  localparam int B  = 8;
  localparam int NB = W / B;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         carry_in  = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  always #5 clk = ~clk;

  csel_pipe_adder #(.WIDTH(W), .BLOCK(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   check_cnt = 0;
  int   err_cnt   = 0;
  int   out_cnt   = 0;
  bit   verbose   = 1'b1;
  bit   rnd_done  = 1'b0;

  logic         hold_valid = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout;
  logic         hold_ovf;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, independent of the a + ~b + 1 trick.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sv, input logic cv);
    exp_t   e;
    longint ua, ub, sa, sbv, r_u, r_s;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    if (sv) begin
      r_u    = ua - ub - longint'(cv);
      r_s    = sa - sbv - longint'(cv);
      e.cout = (r_u >= 0);          // no borrow
    end else begin
      r_u    = ua + ub + longint'(cv);
      r_s    = sa + sbv + longint'(cv);
      e.cout = (r_u >= (longint'(1) <<< W));
    end
    e.sum = r_u[W-1:0];
    e.ovf = (r_s > ((longint'(1) <<< (W-1)) - 1)) || (r_s < -(longint'(1) <<< (W-1)));
    return e;
  endfunction

  // Monitor: sample between edges, when inputs and outputs are settled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      hold_valid = 1'b0;
    end else begin
      check_val("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (hold_valid) begin
        check_val("stall_valid", 64'(out_valid), 64'd1);
        check_val("stall_sum",   64'(sum),       64'(hold_sum));
        check_val("stall_cout",  64'(cout),      64'(hold_cout));
        check_val("stall_ovf",   64'(overflow),  64'(hold_ovf));
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(a, b, sub, carry_in));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("sum",      64'(sum),      64'(e.sum));
          check_val("cout",     64'(cout),     64'(e.cout));
          check_val("overflow", 64'(overflow), 64'(e.ovf));
          if (verbose)
            $display("out #%0d sum=%h cout=%b ovf=%b", out_cnt, sum, cout, overflow);
        end
        out_cnt++;
      end
      hold_valid = out_valid && !out_ready;
      hold_sum   = sum;
      hold_cout  = cout;
      hold_ovf   = overflow;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic sv, input logic cv);
    a        = av;
    b        = bv;
    sub      = sv;
    carry_in = cv;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        return;
      end
      step();
    end
    check_val("send_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (sb_q.size() == 0) break;
      step();
    end
    check_val("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Send one beat into an empty pipeline and count cycles until out_valid.
  task automatic measure_latency(input string tag, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic sv, input logic cv);
    int n;
    out_ready = 1'b1;
    send(av, bv, sv, cv);
    in_valid = 1'b0;
    n = 1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      step();
    end
    check_val(tag, 64'(n), 64'(NB));
    step();
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int snap;

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_sum",       64'(sum),       64'd0);
    check_val("rst_cout",      64'(cout),      64'd0);
    check_val("rst_overflow",  64'(overflow),  64'd0);
    rst = 1'b0;
    step();
    @(negedge clk);
    check_val("in_ready_after_rst", 64'(in_ready), 64'd1);
    step();

    // Carry ripples through every slice; also measures latency
    measure_latency("latency_first", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

    // Subtract, borrow, signed overflow, carry/borrow-in
    send(32'd5, 32'd3, 1'b1, 1'b0);
    send(32'd3, 32'd5, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'd1, 1'b1, 1'b0);
    send(32'd10, 32'd3, 1'b1, 1'b1);
    send(32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();

    // Backpressure: downstream stalls while the stream is still arriving
    snap = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) step();
        out_ready = 1'b0;
        repeat (7) step();
        out_ready = 1'b1;
      end
    join
    drain();
    check_val("bp_count", 64'(out_cnt - snap), 64'd8);

    // Reset with beats in flight: none of them may surface
    send(32'd100, 32'd1, 1'b0, 1'b0);
    send(32'd200, 32'd2, 1'b0, 1'b0);
    send(32'd300, 32'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_flush_valid", 64'(out_valid), 64'd0);
    snap = out_cnt;
    repeat (10) step();
    check_val("rst_flush_none", 64'(out_cnt - snap), 64'd0);
    measure_latency("latency_after_rst", 32'd42, 32'd58, 1'b0, 1'b0);

    // Random regression with random gaps and backpressure
    verbose = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
          end
          send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule
